his_peak_finder: RTL and testbench

- Downstream stage of the histogram builder. Started once a coarse or fine histogram acquisition has finished (dataFinish).
- Reads every bin of the histogram memory through a synchronous read port and finds the maximum bin.
- Then reads the two neighbouring bins so the ranging logic can interpolate.
- Results are held stable for the depth/ranging stage until the next start.

---
 rtl/his_peak_finder.sv | 131 +++++++++++++
 tb/tb_his_peak_finder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/his_peak_finder.sv
// Histogram peak finder: scans every bin through a synchronous read port,
// keeps the first maximum, then fetches its two neighbours for interpolation.
module his_peak_finder #(
  parameter int NB_W     = 10,
  parameter int NUM_BINS = 1024,
  parameter int CNT_W    = 21
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [CNT_W-1:0] min_count,
  output logic             rd_en,
  output logic [NB_W-1:0]  rd_addr,
  input  logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             peak_found,
  output logic [NB_W-1:0]  peak_addr,
  output logic [CNT_W-1:0] peak_count,
  output logic [CNT_W-1:0] left_count,
  output logic [CNT_W-1:0] right_count
);

  localparam logic [NB_W-1:0] LAST = NB_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, NEIGH, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       nph;
  logic             vld_q;
  logic [NB_W-1:0]  addr_q;
  logic [CNT_W-1:0] minc_q, max_q, max_nxt, lcap_q;
  logic [NB_W-1:0]  idx_q, idx_nxt;
  logic             upd;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start)    state_nxt = SCAN;
      SCAN:  if (!rd_en)   state_nxt = NEIGH;
      NEIGH: if (nph == 2) state_nxt = DONE;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Strict compare keeps the lowest address on ties; the final index is
  // needed combinationally on the drain edge to issue the left neighbour.
  always_comb begin
    upd     = (state == SCAN) && vld_q && (rd_data > max_q);
    max_nxt = upd ? rd_data : max_q;
    idx_nxt = upd ? addr_q  : idx_q;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      peak_found  <= 1'b0;
      peak_addr   <= '0;
      peak_count  <= '0;
      left_count  <= '0;
      right_count <= '0;
      nph         <= '0;
      vld_q       <= 1'b0;
      addr_q      <= '0;
      minc_q      <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      lcap_q      <= '0;
    end else begin
      vld_q  <= rd_en;
      addr_q <= rd_addr;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          minc_q  <= min_count;
          max_q   <= '0;
          idx_q   <= '0;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
        end
        SCAN: begin
          max_q <= max_nxt;
          idx_q <= idx_nxt;
          if (rd_en) begin
            if (rd_addr == LAST) rd_en   <= 1'b0;
            else                 rd_addr <= rd_addr + 1'b1;
          end else begin
            rd_en   <= (idx_nxt != '0);
            rd_addr <= idx_nxt - 1'b1;
            nph     <= '0;
          end
        end
        NEIGH: begin
          nph <= nph + 1'b1;
          case (nph)
            2'd0: begin
              rd_en   <= (idx_q != LAST);
              rd_addr <= idx_q + 1'b1;
            end
            2'd1: begin
              rd_en  <= 1'b0;
              lcap_q <= vld_q ? rd_data : '0;
            end
            default: begin
              // Publish all results together so they stay coherent.
              right_count <= vld_q ? rd_data : '0;
              left_count  <= lcap_q;
              peak_addr   <= idx_q;
              peak_count  <= max_q;
              peak_found  <= (max_q >= minc_q);
              done        <= 1'b1;
            end
          endcase
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_his_peak_finder.sv
// Directed bench for his_peak_finder with a 16-bin synchronous memory model.
module tb_his_peak_finder;
  localparam int NB_W = 4, NUM_BINS = 16, CNT_W = 21;
  localparam logic [CNT_W-1:0] JUNK = 21'h1FFFFF;

  logic             clk = 0, res = 0, start = 0;
  logic [CNT_W-1:0] min_count = 0, rd_data;
  logic             rd_en, busy, done, peak_found;
  logic [NB_W-1:0]  rd_addr, peak_addr;
  logic [CNT_W-1:0] peak_count, left_count, right_count;

  logic [CNT_W-1:0] mem [NUM_BINS];
  logic             en_log   [32];
  logic [NB_W-1:0]  addr_log [32];
  int               done_cyc, n_done;
  int               checks = 0, failures = 0;

  his_peak_finder #(.NB_W(NB_W), .NUM_BINS(NUM_BINS), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .min_count(min_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .peak_found(peak_found), .peak_addr(peak_addr),
    .peak_count(peak_count), .left_count(left_count), .right_count(right_count)
  );

  always #5 clk = ~clk;

  // Unread cycles return a huge value that must never win the compare.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : JUNK;

  // Pulse start, then log rd_en/rd_addr for cycle k (after edge Ek).
  task automatic run_scan(input logic [CNT_W-1:0] mc, input bit repulse);
    @(negedge clk); start = 1; min_count = mc;
    @(posedge clk); #1 start = 0; min_count = JUNK;
    done_cyc = -1; n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      if (repulse && (c == 3 || c == 10)) start = 1;
      @(negedge clk);
      en_log[c-1] = rd_en; addr_log[c-1] = rd_addr;
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = c - 1; end
      @(posedge clk); #1 start = 0;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rd_en !== 0 || rd_addr !== 0 || busy !== 0 || done !== 0) begin
      failures++; $display("FAIL reset_ctrl got en=%b addr=%0d busy=%b done=%b exp all 0", rd_en, rd_addr, busy, done); end
    checks++; if (peak_found !== 0 || peak_addr !== 0 || peak_count !== 0 || left_count !== 0 || right_count !== 0) begin
      failures++; $display("FAIL reset_results got f=%b a=%0d p=%0d l=%0d r=%0d exp all 0", peak_found, peak_addr, peak_count, left_count, right_count); end
    @(negedge clk); res = 1;
  endtask

  task automatic test_ramp;
    bit seq_ok = 1;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = CNT_W'(i);
    run_scan(5, 0);
    checks++; if (done_cyc !== 20 || n_done !== 1) begin
      failures++; $display("FAIL ramp_latency got cyc=%0d n=%0d exp cyc=20 n=1", done_cyc, n_done); end
    for (int k = 0; k < NUM_BINS; k++) if (en_log[k] !== 1 || addr_log[k] !== NB_W'(k)) seq_ok = 0;
    checks++; if (!seq_ok || en_log[16] !== 0) begin
      failures++; $display("FAIL ramp_addr_seq got ok=%b gap_en=%b exp ok=1 gap_en=0", seq_ok, en_log[16]); end
    checks++; if (en_log[17] !== 1 || addr_log[17] !== 14 || en_log[18] !== 0) begin
      failures++; $display("FAIL ramp_neigh_rd got l_en=%b l_a=%0d r_en=%b exp 1 14 0", en_log[17], addr_log[17], en_log[18]); end
    checks++; if (peak_addr !== 15 || peak_count !== 15 || left_count !== 14 || right_count !== 0 || peak_found !== 1) begin
      failures++; $display("FAIL ramp_result got a=%0d p=%0d l=%0d r=%0d f=%b exp 15 15 14 0 1", peak_addr, peak_count, left_count, right_count, peak_found); end
    checks++; if (busy !== 0 || done !== 0) begin
      failures++; $display("FAIL ramp_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_first_bin;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 3;
    mem[0] = 100;
    run_scan(5, 0);
    checks++; if (en_log[17] !== 0 || en_log[18] !== 1 || addr_log[18] !== 1) begin
      failures++; $display("FAIL first_neigh_rd got l_en=%b r_en=%b r_a=%0d exp 0 1 1", en_log[17], en_log[18], addr_log[18]); end
    checks++; if (peak_addr !== 0 || peak_count !== 100 || left_count !== 0 || right_count !== 3 || peak_found !== 1) begin
      failures++; $display("FAIL first_result got a=%0d p=%0d l=%0d r=%0d f=%b exp 0 100 0 3 1", peak_addr, peak_count, left_count, right_count, peak_found); end
  endtask

  task automatic test_tie;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 1;
    mem[4] = 50; mem[9] = 50; mem[3] = 7; mem[5] = 8;
    run_scan(0, 0);
    checks++; if (peak_addr !== 4 || peak_count !== 50 || left_count !== 7 || right_count !== 8 || peak_found !== 1) begin
      failures++; $display("FAIL tie_result got a=%0d p=%0d l=%0d r=%0d f=%b exp 4 50 7 8 1", peak_addr, peak_count, left_count, right_count, peak_found); end
  endtask

  task automatic test_not_found;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 2;
    run_scan(3, 0);
    checks++; if (n_done !== 1 || done_cyc !== 20) begin
      failures++; $display("FAIL nf_done got n=%0d cyc=%0d exp 1 20", n_done, done_cyc); end
    checks++; if (peak_addr !== 0 || peak_count !== 2 || peak_found !== 0 || left_count !== 0 || right_count !== 2) begin
      failures++; $display("FAIL nf_result got a=%0d p=%0d f=%b l=%0d r=%0d exp 0 2 0 0 2", peak_addr, peak_count, peak_found, left_count, right_count); end
  endtask

  task automatic test_start_ignored;
    bit seq_ok = 1;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = CNT_W'(i);
    run_scan(0, 1);
    for (int k = 0; k < NUM_BINS; k++) if (en_log[k] !== 1 || addr_log[k] !== NB_W'(k)) seq_ok = 0;
    checks++; if (!seq_ok || n_done !== 1 || done_cyc !== 20) begin
      failures++; $display("FAIL restart_ignored got ok=%b n=%0d cyc=%0d exp 1 1 20", seq_ok, n_done, done_cyc); end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = CNT_W'((i * 3) % 16);
    @(negedge clk); start = 1; min_count = 16;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    #1 res = 0; #1;
    checks++; if (rd_en !== 0 || rd_addr !== 0 || busy !== 0 || done !== 0) begin
      failures++; $display("FAIL midrst_ctrl got en=%b addr=%0d busy=%b done=%b exp all 0", rd_en, rd_addr, busy, done); end
    checks++; if (peak_found !== 0 || peak_addr !== 0 || peak_count !== 0 || left_count !== 0 || right_count !== 0) begin
      failures++; $display("FAIL midrst_results got f=%b a=%0d p=%0d l=%0d r=%0d exp all 0", peak_found, peak_addr, peak_count, left_count, right_count); end
    repeat (4) begin @(negedge clk); if (done) nd++; end
    res = 1;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd !== 0) begin
      failures++; $display("FAIL midrst_no_done got %0d done pulses exp 0", nd); end
    run_scan(16, 0);
    checks++; if (n_done !== 1 || done_cyc !== 20) begin
      failures++; $display("FAIL midrst_rerun_done got n=%0d cyc=%0d exp 1 20", n_done, done_cyc); end
    checks++; if (peak_addr !== 5 || peak_count !== 15 || left_count !== 12 || right_count !== 2 || peak_found !== 0) begin
      failures++; $display("FAIL midrst_rerun_result got a=%0d p=%0d l=%0d r=%0d f=%b exp 5 15 12 2 0", peak_addr, peak_count, left_count, right_count, peak_found); end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_first_bin;
    test_tie;
    test_not_found;
    test_start_ignored;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
